// File: rtl/avm_read_checker_if.sv
// Read-data path bundle between the SDRAM read master side and avm_read_checker.
// The master modport drives the stimulus; the slave modport returns the check results.
interface avm_read_checker_if;
  logic        start_triger;
  logic        read_valid_in;
  logic [15:0] rdata_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic        stray_valid;
  logic [15:0] err_count;
  logic [7:0]  first_err_index;
  logic [15:0] first_err_data;

  modport master (
    output start_triger, read_valid_in, rdata_in,
    input  busy, done, pass, timeout, stray_valid,
           err_count, first_err_index, first_err_data
  );

  modport slave (
    input  start_triger, read_valid_in, rdata_in,
    output busy, done, pass, timeout, stray_valid,
           err_count, first_err_index, first_err_data
  );
endinterface

// File: rtl/avm_read_checker.sv
// Checks SDRAM read-back data against the incrementing write pattern (DATA_SEED + N)
// and reports pass/fail, error statistics, timeout and stray-valid status.
module avm_read_checker #(
  parameter int unsigned   BURST_LEN      = 128,
  parameter logic [15:0]   DATA_SEED      = 16'h0000,
  parameter int unsigned   TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  avm_read_checker_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LAST_IDX = 8'(BURST_LEN - 1);

  logic [1:0]    state;
  logic [7:0]    word_idx;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   expected;
  logic          mismatch;

  logic          pass_q;
  logic          timeout_q;
  logic          stray_q;
  logic [15:0]   err_q;
  logic [7:0]    first_idx_q;
  logic [15:0]   first_data_q;

  assign expected = DATA_SEED + {8'h00, word_idx};
  assign mismatch = (bus.rdata_in != expected);

  // NOTE: every register below uses non-blocking assignments so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      word_idx     <= '0;
      tmo_cnt      <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      stray_q      <= 1'b0;
      err_q        <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_triger) begin
            state        <= ST_CHECK;
            word_idx     <= '0;
            tmo_cnt      <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            stray_q      <= 1'b0;
            err_q        <= '0;
            first_idx_q  <= '0;
            first_data_q <= '0;
          end else if (bus.read_valid_in) begin
            stray_q <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (bus.read_valid_in) begin
            if (mismatch) begin
              if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
              // err_q is cleared on start and saturates, so zero means first miss.
              if (err_q == 16'h0000) begin
                first_idx_q  <= word_idx;
                first_data_q <= bus.rdata_in;
              end
            end
            word_idx <= word_idx + 8'd1;
            tmo_cnt  <= '0;
            if (word_idx == LAST_IDX) begin
              state  <= ST_DONE;
              pass_q <= !mismatch && (err_q == 16'h0000);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= ST_DONE;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          if (bus.read_valid_in) stray_q <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy            = (state == ST_CHECK);
  assign bus.done            = (state == ST_DONE);
  assign bus.pass            = pass_q;
  assign bus.timeout         = timeout_q;
  assign bus.stray_valid     = stray_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_index = first_idx_q;
  assign bus.first_err_data  = first_data_q;

endmodule

// File: doc/avm_read_checker.md
Name: avm_read_checker

Overview:
- Sits directly downstream of avm_read_control, on the same read-data path.
- Consumes the 16-bit read data words and their valid strobes returned from the SDRAM read master.
- Compares each word against the write pattern. The team's write pattern is fixed as word N = DATA_SEED + N (mod 2^16) from the burst start address.
- Reports pass/fail, a saturating error count, first-error details, timeout and stray-data flags for board-level LEDs/probes.

Parameters:
- BURST_LEN, 128: words expected per check run; legal range 1..255, matching the 8-bit burst size.
- DATA_SEED, 16'h0000: value of word 0 in the expected pattern.
- TIMEOUT_CYCLES, 4096: maximum idle cycles allowed between start and the first valid word, or between consecutive valid words; legal range >= 2.

Ports:
- clk, input, 1: single clock for the whole block (100 MHz ref_clk domain).
- reset_n, input, 1: asynchronous, active-low reset.
- start_triger, input, 1: single-cycle pulse; arms the checker for one run. Pulse it in the same cycle as the read start trigger.
- read_valid_in, input, 1: rdata_in is valid this cycle.
- rdata_in, input, 16: read data word.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse at end of run.
- pass, output, 1: result of the last completed run; held until the next start.
- timeout, output, 1: last run aborted by timeout; held until the next start.
- stray_valid, output, 1: sticky flag; read_valid_in was seen while not busy. Cleared on start.
- err_count, output, 16: mismatches in the current/last run; saturates at 16'hFFFF.
- first_err_index, output, 8: word index of the first mismatch.
- first_err_data, output, 16: rdata_in value of the first mismatch.

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy, done, pass, timeout and stray_valid = 0. err_count, first_err_index and first_err_data = 0. Internal word_idx = 0, tmo_cnt = 0.
- FSM states: IDLE, CHECK, DONE.
- IDLE:
  - start_triger=1 moves to CHECK next edge.
  - On that edge: clear err_count, first_err_*, pass, timeout, stray_valid; set word_idx=0, tmo_cnt=0, busy=1.
  - read_valid_in=1 in IDLE (start_triger=0) sets stray_valid. Data is not checked.
  - start_triger and read_valid_in in the same IDLE cycle: the start is taken; the word is neither checked nor flagged.
- CHECK:
  - Each cycle with read_valid_in=1: expected = DATA_SEED + word_idx, 16-bit wraparound add with word_idx zero-extended.
  - On mismatch: err_count increments, saturating. If this is the first mismatch of the run, latch word_idx into first_err_index and rdata_in into first_err_data.
  - word_idx increments and tmo_cnt clears.
  - The valid word with word_idx == BURST_LEN-1 moves to DONE.
  - Cycle with read_valid_in=0: tmo_cnt increments. When tmo_cnt reaches TIMEOUT_CYCLES-1, go to DONE with timeout=1.
  - start_triger in CHECK is ignored; no restart.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=1 iff err_count==0 and timeout==0, evaluated including the final word's compare.
  - Returns to IDLE next edge.
  - read_valid_in in DONE sets stray_valid.
  - start_triger in DONE is ignored.
- Latency: done pulses on the cycle after the edge that sampled the last valid word, i.e. 2 edges after that word is presented. pass, err_count and first_err_* are stable when done=1.
- Back-to-back valid every cycle is supported with no stalls. The block has no backpressure output.
- Reset mid-run: all outputs return to reset values immediately; no done pulse is produced.

Test Plan:
- Reset, start pulse, then 128 consecutive valids with data 0x0000..0x007F -> done pulses 1 cycle after the last word edge; pass=1, err_count=0, timeout=0.
- Same run with word 5 = 0xDEAD and word 9 = 0x0000 -> pass=0, err_count=2, first_err_index=5, first_err_data=0xDEAD.
- DATA_SEED=16'hFFF0, BURST_LEN=32, data FFF0..FFFF,0000..000F with gaps of 1–3 idle cycles -> pass=1; confirms wraparound and gap tolerance.
- Start, then 10 correct words and no further valids -> done after TIMEOUT_CYCLES idle cycles; timeout=1, pass=0, err_count=0.
- Valid pulse before start -> stray_valid=1; a subsequent start clears it. Second start mid-CHECK -> ignored, word_idx continues.
- Assert reset_n=0 mid-CHECK at word 60 -> all outputs 0 asynchronously. A new start plus a full correct burst -> pass=1.
